// File: rtl/ring_ctr_decoder_pkg.sv
// Shared ring-counter definitions: lock state and the rotate / one-hot helpers
// used by the decoder and by the ring counter benches.
package ring_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } ring_state_e;

  // Helpers take a zero-extended vector plus the live ring width, so any ring up to RING_MAXW bits can share them.
  localparam int RING_MAXW = 64;

  function automatic logic [RING_MAXW-1:0] rotr(input logic [RING_MAXW-1:0] v,
                                                input int width);
    logic [RING_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < RING_MAXW - 1; i++) begin
      if (i < width - 1) r[i] = v[i+1];
    end
    for (int i = 0; i < RING_MAXW; i++) begin
      if (i == width - 1) r[i] = v[0];
    end
    return r;
  endfunction

  function automatic logic is_onehot(input logic [RING_MAXW-1:0] v,
                                     input int width);
    int n;
    n = 0;
    for (int i = 0; i < RING_MAXW; i++) begin
      if (i < width && v[i]) n++;
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/ring_ctr_decoder_onehot_to_bin.sv
// Combinational one-hot to binary index; the lowest set bit wins if several are set.
module onehot_to_bin #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot_i,
  output logic [IDXW-1:0]  bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (onehot_i[i]) bin_o = IDXW'(i);
    end
  end

endmodule

// File: rtl/ring_ctr_decoder.sv
// Receiver/checker for the one-hot ring counter bus: decodes the index,
// tracks rotate-right sequence lock and counts one-hot / sequence errors.
module ring_ctr_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int IDXW     = $clog2(WIDTH),
  parameter int LOCK_CNT = 2,
  parameter int ERR_CNTW = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    ring_in,
  output logic [IDXW-1:0]     idx_out,
  output logic                idx_valid,
  output logic                locked,
  output logic                onehot_err,
  output logic                seq_err,
  output logic                wrap_pulse,
  output logic [ERR_CNTW-1:0] err_count,
  output ring_state_e         dbg_state
);

  localparam int GCW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  // Valid/ready contract: the ring source has no back-pressure; every cycle
  // with in_valid=1 is consumed, and in_valid=0 cycles leave all state untouched.

  ring_state_e          state_q;
  logic [GCW-1:0]       good_q;
  logic [WIDTH-1:0]     prev_q;
  logic                 prev_ok_q;
  logic [IDXW-1:0]      idx_q;
  logic                 idx_valid_q;
  logic                 onehot_err_q;
  logic                 seq_err_q;
  logic                 wrap_q;
  logic [ERR_CNTW-1:0]  err_cnt_q;

  logic [RING_MAXW-1:0] in_ext;
  logic [RING_MAXW-1:0] prev_ext;
  logic                 oh;
  logic                 match;
  logic [IDXW-1:0]      bin_idx;
  logic [GCW-1:0]       good_d;
  logic                 err_event;
  logic [ERR_CNTW-1:0]  err_cnt_d;

  always_comb begin
    in_ext               = '0;
    in_ext[WIDTH-1:0]    = ring_in;
    prev_ext             = '0;
    prev_ext[WIDTH-1:0]  = prev_q;
  end

  assign oh    = is_onehot(in_ext, WIDTH);
  assign match = prev_ok_q && (in_ext == rotr(prev_ext, WIDTH));

  onehot_to_bin #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_onehot_to_bin (
    .onehot_i (ring_in),
    .bin_o    (bin_idx)
  );

  assign good_d    = good_q + GCW'(1);
  // A sequence error only exists while locked; in HUNT a mismatch just restarts the count.
  assign err_event = in_valid && (!oh || ((state_q == LOCKED) && !match));
  assign err_cnt_d = (err_event && (err_cnt_q != '1)) ? err_cnt_q + ERR_CNTW'(1) : err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= HUNT;
      good_q       <= '0;
      prev_q       <= '0;
      prev_ok_q    <= 1'b0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      onehot_err_q <= 1'b0;
      seq_err_q    <= 1'b0;
      wrap_q       <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      idx_valid_q  <= 1'b0;
      onehot_err_q <= 1'b0;
      seq_err_q    <= 1'b0;
      wrap_q       <= 1'b0;
      err_cnt_q    <= err_cnt_d;
      if (in_valid) begin
        if (oh) begin
          idx_q       <= bin_idx;
          idx_valid_q <= 1'b1;
          prev_q      <= ring_in;
          prev_ok_q   <= 1'b1;
          case (state_q)
            HUNT: begin
              if (!match) begin
                good_q <= '0;
              end else if (good_d == GCW'(LOCK_CNT)) begin
                state_q <= LOCKED;
                good_q  <= '0;
              end else begin
                good_q <= good_d;
              end
            end
            LOCKED: begin
              if (match) begin
                wrap_q <= ring_in[0];
              end else begin
                seq_err_q <= 1'b1;
                state_q   <= HUNT;
                good_q    <= '0;
              end
            end
            default: begin
              state_q <= HUNT;
              good_q  <= '0;
            end
          endcase
        end else begin
          onehot_err_q <= 1'b1;
          prev_ok_q    <= 1'b0;
          good_q       <= '0;
          state_q      <= HUNT;
        end
      end
    end
  end

  assign idx_out    = idx_q;
  assign idx_valid  = idx_valid_q;
  assign locked     = (state_q == LOCKED);
  assign onehot_err = onehot_err_q;
  assign seq_err    = seq_err_q;
  assign wrap_pulse = wrap_q;
  assign err_count  = err_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ring_ctr_decoder.sv
// Bench for ring_ctr_decoder: directed scenarios followed by random traffic,
// each cycle compared against an index-arithmetic reference model.
module tb_ring_ctr_decoder;
  import ring_pkg::*;

  localparam int W   = 4;
  localparam int LC  = 2;
  localparam int EW  = 8;
  localparam int EWS = 2;
  localparam int IW  = $clog2(W);

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   ring_in = '0;

  logic [IW-1:0]  idx_out, s_idx_out;
  logic           idx_valid, s_idx_valid;
  logic           locked, s_locked;
  logic           onehot_err, s_onehot_err;
  logic           seq_err, s_seq_err;
  logic           wrap_pulse, s_wrap_pulse;
  logic [EW-1:0]  err_count;
  logic [EWS-1:0] s_err_count;
  ring_state_e    dbg_state, s_dbg_state;

  int total = 0;
  int bad   = 0;

  // Reference model: ring position as an integer, -1 when no usable reference.
  int m_prev, m_streak, m_idx, m_err, m_err_s;
  bit m_locked, e_iv, e_oh, e_seq, e_wrap;

  always #5 clk = ~clk;

  ring_ctr_decoder #(.WIDTH(W), .LOCK_CNT(LC), .ERR_CNTW(EW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .ring_in(ring_in),
    .idx_out(idx_out), .idx_valid(idx_valid), .locked(locked),
    .onehot_err(onehot_err), .seq_err(seq_err), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  ring_ctr_decoder #(.WIDTH(W), .LOCK_CNT(LC), .ERR_CNTW(EWS)) dut_sat (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .ring_in(ring_in),
    .idx_out(s_idx_out), .idx_valid(s_idx_valid), .locked(s_locked),
    .onehot_err(s_onehot_err), .seq_err(s_seq_err), .wrap_pulse(s_wrap_pulse),
    .err_count(s_err_count), .dbg_state(s_dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = -1; m_streak = 0; m_idx = 0; m_err = 0; m_err_s = 0;
    m_locked = 0; e_iv = 0; e_oh = 0; e_seq = 0; e_wrap = 0;
  endtask

  task automatic count_err();
    if (m_err < (2 ** EW) - 1) m_err++;
    if (m_err_s < (2 ** EWS) - 1) m_err_s++;
  endtask

  task automatic model_step(input bit v, input logic [W-1:0] d);
    int k;
    bit ok;
    e_iv = 0; e_oh = 0; e_seq = 0; e_wrap = 0;
    if (v) begin
      if ($countones(d) == 1) begin
        k = 0;
        for (int i = 0; i < W; i++) if (d[i]) k = i;
        e_iv  = 1;
        m_idx = k;
        // Rotate-right moves the hot bit one position down, wrapping W-1 after 0.
        ok = (m_prev >= 0) && (k == (m_prev + W - 1) % W);
        if (!m_locked) begin
          if (ok) begin
            m_streak++;
            if (m_streak == LC) begin m_locked = 1; m_streak = 0; end
          end else m_streak = 0;
        end else if (ok) begin
          e_wrap = (k == 0);
        end else begin
          e_seq = 1; m_locked = 0; m_streak = 0; count_err();
        end
        m_prev = k;
      end else begin
        e_oh = 1; m_prev = -1; m_streak = 0; m_locked = 0; count_err();
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " idx_out"}, 32'(idx_out), 32'(m_idx));
    chk({tag, " idx_valid"}, 32'(idx_valid), 32'(e_iv));
    chk({tag, " locked"}, 32'(locked), 32'(m_locked));
    chk({tag, " onehot_err"}, 32'(onehot_err), 32'(e_oh));
    chk({tag, " seq_err"}, 32'(seq_err), 32'(e_seq));
    chk({tag, " wrap_pulse"}, 32'(wrap_pulse), 32'(e_wrap));
    chk({tag, " err_count"}, 32'(err_count), 32'(m_err));
    chk({tag, " dbg_state"}, 32'(dbg_state), 32'(m_locked ? LOCKED : HUNT));
    chk({tag, " sat_err_count"}, 32'(s_err_count), 32'(m_err_s));
    chk({tag, " sat_locked"}, 32'(s_locked), 32'(m_locked));
  endtask

  task automatic step(input bit v, input logic [W-1:0] d, input string tag);
    @(negedge clk);
    rstn = 1'b1; in_valid = v; ring_in = d;
    @(posedge clk); #1;
    model_step(v, d);
    check_all(tag);
  endtask

  // Reset is applied with a valid sample present to show it takes priority.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rstn = 1'b0; in_valid = 1'b1; ring_in = 4'b0001;
    @(posedge clk); #1;
    model_reset();
    check_all(tag);
  endtask

  task automatic lock_seq(input string tag, input int gap);
    logic [W-1:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b1000; seq[2] = 4'b0100; seq[3] = 4'b0010; seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], $sformatf("%s s%0d", tag, i));
      for (int g = 0; g < gap; g++) step(1'b0, 4'($urandom_range(0, 15)), $sformatf("%s gap%0d", tag, i));
    end
  endtask

  initial begin
    logic [W-1:0] d;
    int exp_sat [5];
    exp_sat[0] = 1; exp_sat[1] = 2; exp_sat[2] = 3; exp_sat[3] = 3; exp_sat[4] = 3;
    model_reset();

    do_reset("reset");
    lock_seq("lock", 0);
    chk("lock locked", 32'(locked), 32'd1);

    step(1'b1, 4'b0110, "nonoh");
    chk("nonoh idx_hold", 32'(idx_out), 32'd0);
    step(1'b1, 4'b0001, "nonoh r0");
    step(1'b1, 4'b1000, "nonoh r1");
    step(1'b1, 4'b0100, "nonoh r2");

    step(1'b1, 4'b0010, "seq p0");
    step(1'b1, 4'b0001, "seq p1");
    step(1'b1, 4'b1000, "seq p2");
    step(1'b1, 4'b0010, "seq bad");
    chk("seq idx", 32'(idx_out), 32'd1);
    step(1'b1, 4'b0001, "seq r0");
    step(1'b1, 4'b1000, "seq r1");

    do_reset("reset2");
    lock_seq("gap", 3);

    do_reset("midlock");
    step(1'b1, 4'b0100, "relock0");
    step(1'b1, 4'b0010, "relock1");
    step(1'b1, 4'b0001, "relock2");

    do_reset("reset3");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b0000, $sformatf("zero%0d", i));
      chk($sformatf("zero%0d sat", i), 32'(s_err_count), 32'(exp_sat[i]));
    end

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rand reset");
      end else begin
        d = '0;
        if (m_prev >= 0 && $urandom_range(0, 99) < 75) d[(m_prev + W - 1) % W] = 1'b1;
        else if ($urandom_range(0, 1) == 1) d[$urandom_range(0, W - 1)] = 1'b1;
        else d = 4'($urandom_range(0, 15));
        step($urandom_range(0, 3) != 0, d, $sformatf("rand%0d", n));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ring_ctr_decoder.md
Name: ring_ctr_decoder

Overview:
- Receiver/checker for the team's one-hot ring counter bus.
- Samples the WIDTH-bit one-hot vector and converts it to a binary index.
- Checks every sample is one-hot and that successive samples follow the ring's rotate-right order: out[WIDTH-1] <= out[0], out[i] <= out[i+1]. For WIDTH=4 the sequence is 0001 -> 1000 -> 0100 -> 0010 -> 0001.
- Sits downstream of a ring counter (or a link carrying its state) and gives status to control and debug logic.

Parameters:
- WIDTH, 4, ring width in bits; must be >= 2.
- IDXW, $clog2(WIDTH), width of the binary index output.
- LOCK_CNT, 2, number of consecutive correct transitions required to declare lock; must be >= 1.
- ERR_CNTW, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  synchronous, active-low reset.
- in_valid  input  1  ring_in is sampled this cycle.
- ring_in  input  WIDTH  one-hot ring state under check.
- idx_out  output  IDXW  binary index of the set bit in the last valid one-hot sample.
- idx_valid  output  1  one-cycle pulse when idx_out updates.
- locked  output  1  sequence lock achieved.
- onehot_err  output  1  one-cycle pulse: the valid sample was not one-hot (zero bits or more than one bit set).
- seq_err  output  1  one-cycle pulse while locked: the one-hot sample is not rotr(prev).
- wrap_pulse  output  1  one-cycle pulse while locked when the ring returns to bit 0.
- err_count  output  ERR_CNTW  saturating count of onehot_err plus seq_err events.

Behaviour:
- Reset:
  - Applied on the clk edge where rstn=0; overrides everything, including mid-lock.
  - Clears all outputs to 0, state to HUNT, good_cnt to 0, prev to 0, prev_ok to 0.
- Definitions:
  - rotr(v) = {v[0], v[WIDTH-1:1]}.
  - oh = popcount(ring_in) == 1.
  - match = prev_ok && (ring_in == rotr(prev)).
- Latency: all outputs are registered and reflect the sample taken at edge N in the cycle after edge N.
- in_valid=0: no state change; idx_out, locked and err_count hold; all pulses are 0.
- Any valid one-hot sample, in any state:
  - idx_out <= index of the set bit; idx_valid <= 1.
  - prev <= ring_in; prev_ok <= 1.
- Any valid non-one-hot sample, in any state:
  - onehot_err <= 1; prev_ok <= 0; good_cnt <= 0; idx_out holds.
- FSM states: HUNT, LOCKED; locked = (state == LOCKED).
- HUNT:
  - oh && match: good_cnt++. If the new good_cnt == LOCK_CNT, go to LOCKED and clear good_cnt.
  - oh && !match: good_cnt <= 0. The sample becomes the new reference, so a restart is allowed.
  - seq_err is never raised in HUNT.
- LOCKED:
  - oh && match: stay in LOCKED. wrap_pulse <= 1 if ring_in[0].
  - oh && !match: seq_err <= 1, go to HUNT, good_cnt <= 0. The offending sample becomes the reference.
  - !oh: onehot_err <= 1, go to HUNT.
- err_count:
  - Increments by 1 on each cycle in which onehot_err or seq_err is set. The two cannot both be set in one cycle.
  - Saturates at 2^ERR_CNTW-1.
  - Cleared only by reset.
- Lock timing: with LOCK_CNT=2 and back-to-back valid samples, locked rises in the cycle after the 3rd correct sample.
- A repeated identical sample (a stalled ring) counts as a mismatch.
- WIDTH=2: rotr swaps the two bits; no special case is needed.

Decomposition:
- Shared package ring_pkg holds:
  - state enum ring_state_e {HUNT, LOCKED}.
  - function rotr.
  - function is_onehot.
- Both functions are parameterised by WIDTH via the module and used by the ring counter benches as well.
- One natural sub-module: onehot_to_bin (combinational, WIDTH to IDXW, priority on the lowest set bit). It is used for idx_out.

Test Plan:
- Lock and decode:
  - Stimulus: after reset, valid each cycle with 0001, 1000, 0100, 0010, 0001.
  - Response: idx_out = 0, 3, 2, 1, 0 with idx_valid each cycle. locked=1 from the cycle after the 3rd sample. wrap_pulse once, after the 5th sample. err_count = 0.
- Non-one-hot while locked:
  - Stimulus: once locked, drive 0110.
  - Response: onehot_err one cycle, locked drops, err_count=1, idx_out holds the previous value.
  - Follow-up: 0001, 1000, 0100 relocks.
- Sequence error:
  - Stimulus: locked with prev=1000, then drive 0010.
  - Response: seq_err one cycle, locked=0, err_count increments, idx_out=1.
  - Follow-up: 0001, 1000 relocks, because 0010 was taken as the new reference.
- Valid gaps:
  - Stimulus: the sequence from the first scenario with in_valid=0 for 3 cycles between samples.
  - Response: identical lock and index behaviour; no pulses during gaps; outputs hold.
- Reset mid-lock:
  - Stimulus: rstn=0 for 1 edge while locked.
  - Response: locked, idx_out and err_count all 0 in the next cycle, state HUNT. Two further correct transitions are needed to relock.
- Counter saturation:
  - Stimulus: ERR_CNTW=2, drive 0000 valid 5 times.
  - Response: five onehot_err pulses; err_count goes 1, 2, 3, 3, 3; locked stays 0.
